// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing constants and helpers for the VGA output path.
// Holds the 640x480@60 default timing, derived totals and sync-window bounds,
// so the sync generator and the object generators agree on one set of numbers.
package vga_sync_gen_pkg;

  // Counter width for pixel_x / pixel_y (covers totals up to 1024).
  localparam int CNT_W = 10;

  // 640x480@60 default timing (25 MHz pixel clock).
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  // Derived totals and sync windows for the default timing.
  localparam int VGA_H_TOTAL  = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL  = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
  localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  // True when lo <= v < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// Modulo-N counter with enable; used for the pixel divider and the H/V raster counters.
// Ports: clk, rst_n (async active-low), i_en (advance), o_cnt (current value),
//        o_wrap (i_en while at N-1, i.e. this edge returns the count to 0).
module mod_counter #(
  parameter int N       = 4,
  parameter int W       = 2,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(N - 1));
  assign o_wrap = i_en & w_last;
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= W'(RST_VAL);
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-enable divider, H/V counters, sync/blank and coordinates.
// Ports: clk, rst_n (async active-low) in; p_tick, video_on, pixel_x[9:0], pixel_y[9:0],
//        hsync, vsync (delayed SYNC_DLY clk to match the registered RGB mux), frame_start out.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int SYNC_POL  = 0,
  parameter int SYNC_DLY  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             p_tick,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIV_PRE  = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;
  localparam logic SYNC_ACT  = (SYNC_POL != 0);
  localparam logic SYNC_IDLE = (SYNC_POL == 0);

  logic [DIV_W-1:0] w_div;
  logic             w_div_wrap;
  logic             w_pre_tick;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;

  logic r_p_tick;
  logic r_video_on;
  logic r_frame_start;
  logic r_hs_raw;
  logic r_vs_raw;

  // Pixel divider, free-running from reset release.
  mod_counter #(.N(CLK_DIV), .W(DIV_W), .RST_VAL(0)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (1'b1),
    .o_cnt  (w_div),
    .o_wrap (w_div_wrap)
  );

  // Counters park at the last pixel of the last line so the first p_tick
  // after reset wraps both to (0,0) and raises frame_start.
  mod_counter #(.N(H_TOTAL), .W(CNT_W), .RST_VAL(H_TOTAL - 1)) u_hcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_p_tick),
    .o_cnt  (w_x),
    .o_wrap (w_h_wrap)
  );

  mod_counter #(.N(V_TOTAL), .W(CNT_W), .RST_VAL(V_TOTAL - 1)) u_vcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_h_wrap),
    .o_cnt  (w_y),
    .o_wrap (w_v_wrap)
  );

  // p_tick is registered, so it is set one edge early: when the divider is
  // about to reach CLK_DIV-1. With CLK_DIV=1 the divider sits at its last
  // value permanently and p_tick stays high from the first edge on.
  assign w_pre_tick = (CLK_DIV == 1) ? w_div_wrap : (w_div == DIV_W'(DIV_PRE));

  // Next raster position; only meaningful in a p_tick cycle.
  assign w_x_nxt = w_h_wrap ? '0 : w_x + 1'b1;
  assign w_y_nxt = w_v_wrap ? '0 : (w_h_wrap ? w_y + 1'b1 : w_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_tick      <= 1'b0;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs_raw      <= SYNC_IDLE;
      r_vs_raw      <= SYNC_IDLE;
    end else begin
      r_p_tick      <= w_pre_tick;
      r_frame_start <= 1'b0;
      if (r_p_tick) begin
        // Decoded from the next position so these change on the same edge as the counters.
        r_video_on    <= in_window(w_x_nxt, 0, H_DISPLAY) && in_window(w_y_nxt, 0, V_DISPLAY);
        r_hs_raw      <= in_window(w_x_nxt, HS_START, HS_END) ? SYNC_ACT : SYNC_IDLE;
        r_vs_raw      <= in_window(w_y_nxt, VS_START, VS_END) ? SYNC_ACT : SYNC_IDLE;
        r_frame_start <= w_v_wrap;
      end
    end
  end

  // Sync delay line runs every clk (not p_tick-gated) so it tracks the RGB mux latency in clk.
  generate
    if (SYNC_DLY == 0) begin : g_sync_direct
      assign hsync = r_hs_raw;
      assign vsync = r_vs_raw;
    end else begin : g_sync_delay
      logic [SYNC_DLY-1:0] r_hs_sr;
      logic [SYNC_DLY-1:0] r_vs_sr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hs_sr <= {SYNC_DLY{SYNC_IDLE}};
          r_vs_sr <= {SYNC_DLY{SYNC_IDLE}};
        end else begin
          r_hs_sr[0] <= r_hs_raw;
          r_vs_sr[0] <= r_vs_raw;
          for (int k = 1; k < SYNC_DLY; k++) begin
            r_hs_sr[k] <= r_hs_sr[k-1];
            r_vs_sr[k] <= r_vs_sr[k-1];
          end
        end
      end

      assign hsync = r_hs_sr[SYNC_DLY-1];
      assign vsync = r_vs_sr[SYNC_DLY-1];
    end
  endgenerate

  assign p_tick      = r_p_tick;
  assign video_on    = r_video_on;
  assign pixel_x     = w_x;
  assign pixel_y     = w_y;
  assign frame_start = r_frame_start;

endmodule
